// File: rtl/enc_pkg.sv
// Shared widths, output-register state type and one-hot legality helper
// for the 8-to-3 encoder slice.
package enc_pkg;

  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  function automatic logic is_onehot(input logic [VEC_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_encoder_8to3_if.sv
// Request-in / result-out valid-ready bus of the 8-to-3 encoder.
interface onehot_encoder_8to3_if;
  import enc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_err;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_err
  );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 encoder with legality flag; PRIORITY picks the
// multi-hot policy (highest set bit vs. forced zero).
module prio_enc8
  import enc_pkg::*;
#(
  parameter int PRIORITY = 1
) (
  input  logic [VEC_W-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  logic [CODE_W-1:0] w_hi;
  logic              w_onehot;

  always_comb begin
    w_hi = '0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      if (vec[i]) w_hi = CODE_W'(i);
    end
  end

  always_comb begin
    w_onehot = is_onehot(vec);
    err      = !w_onehot;
    // Zero input leaves w_hi at 0, so only the multi-hot case needs the policy.
    code     = (w_onehot || (PRIORITY != 0)) ? w_hi : '0;
  end

endmodule

// File: rtl/onehot_encoder_8to3.sv
// Registered one-hot to binary encoder with valid/ready on both sides and a
// saturating count of illegal (zero or multi-hot) request vectors.
module onehot_encoder_8to3
  import enc_pkg::*;
#(
  parameter int PRIORITY  = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_encoder_8to3_if.slave bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ostate_t               r_state;
  ostate_t               w_state_nxt;
  logic [CODE_W-1:0]     r_code;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic [VEC_W-1:0]      w_vec;
  logic [CODE_W-1:0]     w_code;
  logic                  w_err;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_load;

  // Masking keeps an undriven in_vec from reaching the encoder when idle.
  assign w_vec = bus.in_valid ? bus.in_vec : '0;

  prio_enc8 #(.PRIORITY(PRIORITY)) u_enc (
    .vec  (w_vec),
    .code (w_code),
    .err  (w_err)
  );

  assign bus.in_ready  = rst_n & ((r_state == ST_EMPTY) | bus.out_ready);
  assign w_in_xfer     = bus.in_valid & bus.in_ready;
  assign w_out_xfer    = (r_state == ST_FULL) & bus.out_ready;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_code  = r_code;
  assign bus.out_err   = r_err;
  assign err_cnt       = r_err_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_xfer) begin
          w_load = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
      r_err  <= 1'b0;
    end else if (w_load) begin
      r_code <= w_code;
      r_err  <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Bench for onehot_encoder_8to3: two instances (PRIORITY=1/8-bit count and
// PRIORITY=0/2-bit count) share one directed stimulus and a per-cycle model.
module tb_onehot_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_iv;
  logic [7:0] tb_vec;
  logic       tb_ordy;
  logic       tb_clr;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onehot_encoder_8to3_if ifa ();
  onehot_encoder_8to3_if ifb ();

  assign ifa.in_valid  = tb_iv;
  assign ifa.in_vec    = tb_vec;
  assign ifa.out_ready = tb_ordy;
  assign ifb.in_valid  = tb_iv;
  assign ifb.in_vec    = tb_vec;
  assign ifb.out_ready = tb_ordy;

  onehot_encoder_8to3 #(.PRIORITY(1), .ERR_CNT_W(8)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifa),
    .err_clr (tb_clr),
    .err_cnt (cnt_a)
  );

  onehot_encoder_8to3 #(.PRIORITY(0), .ERR_CNT_W(2)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifb),
    .err_clr (tb_clr),
    .err_cnt (cnt_b)
  );

  logic       obs_rdy[2];
  logic       obs_valid[2];
  logic [2:0] obs_code[2];
  logic       obs_err[2];
  int         obs_cnt[2];

  assign obs_rdy[0]   = ifa.in_ready;
  assign obs_rdy[1]   = ifb.in_ready;
  assign obs_valid[0] = ifa.out_valid;
  assign obs_valid[1] = ifb.out_valid;
  assign obs_code[0]  = ifa.out_code;
  assign obs_code[1]  = ifb.out_code;
  assign obs_err[0]   = ifa.out_err;
  assign obs_err[1]   = ifb.out_err;
  assign obs_cnt[0]   = int'(cnt_a);
  assign obs_cnt[1]   = int'(cnt_b);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: encoding from bit population and magnitude of the vector.
  function automatic void model_enc(input logic [7:0] v, input bit prio,
                                    output logic [2:0] c, output logic e);
    int n;
    n = $countones(v);
    e = (n != 1);
    if (n == 0)                c = 3'd0;
    else if (n == 1 || prio)   c = 3'($clog2(int'(v) + 1) - 1);
    else                       c = 3'd0;
  endfunction

  bit         m_prio[2] = '{1'b1, 1'b0};
  int         m_max[2]  = '{255, 3};
  bit         m_valid[2];
  logic [2:0] m_code[2];
  logic       m_err[2];
  int         m_cnt[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] <= 1'b0;
        m_code[k]  <= 3'd0;
        m_err[k]   <= 1'b0;
        m_cnt[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] c;
        logic       e;
        bit         in_x;
        model_enc(tb_vec, m_prio[k], c, e);
        in_x = tb_iv && (!m_valid[k] || tb_ordy);
        if (in_x) begin
          m_valid[k] <= 1'b1;
          m_code[k]  <= c;
          m_err[k]   <= e;
        end else if (m_valid[k] && tb_ordy) begin
          m_valid[k] <= 1'b0;
        end
        if (tb_clr)                                m_cnt[k] <= 0;
        else if (in_x && e && m_cnt[k] < m_max[k]) m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k), int'(obs_rdy[k]),
          int'(rst_n && (!m_valid[k] || tb_ordy)));
      chk($sformatf("out_valid[%0d]", k), int'(obs_valid[k]), int'(m_valid[k]));
      if (m_valid[k]) begin
        chk($sformatf("out_code[%0d]", k), int'(obs_code[k]), int'(m_code[k]));
        chk($sformatf("out_err[%0d]", k), int'(obs_err[k]), int'(m_err[k]));
      end
      chk($sformatf("err_cnt[%0d]", k), obs_cnt[k], m_cnt[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; tb_iv = 1'b1; tb_vec = 8'h01; tb_ordy = 1'b1; tb_clr = 1'b0;

    // Reset with in_valid held high
    repeat (3) step();
    chk("rst_valid_a", int'(ifa.out_valid), 0);
    chk("rst_valid_b", int'(ifb.out_valid), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_ready_a", int'(ifa.in_ready), 0);
    tb_iv = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready_a", int'(ifa.in_ready), 1);
    chk("post_rst_ready_b", int'(ifb.in_ready), 1);
    step();

    // Back-to-back legal sweep
    for (int i = 0; i < 8; i++) begin
      tb_iv = 1'b1; tb_vec = 8'(1 << i);
      @(negedge clk);
      if (i > 0) begin
        chk("sweep_valid", int'(ifa.out_valid), 1);
        chk("sweep_code_a", int'(ifa.out_code), i - 1);
        chk("sweep_code_b", int'(ifb.out_code), i - 1);
        chk("sweep_err_a", int'(ifa.out_err), 0);
      end
      step();
    end
    tb_iv = 1'b0;
    @(negedge clk);
    chk("sweep_last_code", int'(ifa.out_code), 7);
    step();

    // Illegal inputs
    tb_iv = 1'b1; tb_vec = 8'h00;
    step();
    tb_iv = 1'b0;
    @(negedge clk);
    chk("zero_code_a", int'(ifa.out_code), 0);
    chk("zero_err_a", int'(ifa.out_err), 1);
    chk("zero_err_b", int'(ifb.out_err), 1);
    step();
    tb_iv = 1'b1; tb_vec = 8'h24;
    step();
    tb_iv = 1'b0;
    @(negedge clk);
    chk("multi_code_a", int'(ifa.out_code), 5);
    chk("multi_err_a", int'(ifa.out_err), 1);
    chk("multi_code_b", int'(ifb.out_code), 0);
    chk("multi_err_b", int'(ifb.out_err), 1);
    step();
    @(negedge clk);
    chk("illegal_cnt_a", int'(cnt_a), 2);
    chk("illegal_cnt_b", int'(cnt_b), 2);
    step();

    // Backpressure
    tb_ordy = 1'b0; tb_iv = 1'b1; tb_vec = 8'h08;
    step();
    tb_vec = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_code", int'(ifa.out_code), 3);
      chk("bp_valid", int'(ifa.out_valid), 1);
      chk("bp_ready", int'(ifa.in_ready), 0);
    end
    step();
    tb_ordy = 1'b1;
    step();
    tb_iv = 1'b0;
    @(negedge clk);
    chk("bp_next_code", int'(ifa.out_code), 6);
    chk("bp_next_valid", int'(ifa.out_valid), 1);
    step();

    // Saturation
    tb_clr = 1'b1;
    step();
    tb_clr = 1'b0; tb_iv = 1'b1; tb_vec = 8'hFF;
    repeat (5) step();
    tb_iv = 1'b0;
    @(negedge clk);
    chk("sat_cnt_b", int'(cnt_b), 3);
    chk("sat_cnt_a", int'(cnt_a), 5);
    step();
    tb_clr = 1'b1; tb_iv = 1'b1; tb_vec = 8'h00;
    step();
    tb_clr = 1'b0; tb_iv = 1'b0;
    @(negedge clk);
    chk("clr_win_a", int'(cnt_a), 0);
    chk("clr_win_b", int'(cnt_b), 0);
    step();

    // Async reset while holding a result
    tb_ordy = 1'b0; tb_iv = 1'b1; tb_vec = 8'h08;
    step();
    tb_iv = 1'b0;
    @(negedge clk);
    chk("hold_valid", int'(ifa.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid_a", int'(ifa.out_valid), 0);
    chk("async_valid_b", int'(ifb.out_valid), 0);
    repeat (2) step();
    rst_n = 1'b1; tb_ordy = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("discard_valid", int'(ifa.out_valid), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
